// File: rtl/ex_muldiv.sv
// Execute stage: single-cycle RV32I ALU plus a multi-cycle RV32M multiply/divide unit.
// A mul/div op stalls the upstream pipeline until its result is presented, for one cycle, in DONE.
module ex_muldiv #(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic [7:0]      aluop_i,
    input  logic [2:0]      alusel_i,
    input  logic [XLEN-1:0] reg1_i,
    input  logic [XLEN-1:0] reg2_i,
    input  logic [4:0]      wd_i,
    input  logic            wreg_i,
    output logic [4:0]      wd_o,
    output logic            wreg_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            stallreq_o
);
    localparam logic [7:0] OP_ADD = 8'h01, OP_SUB = 8'h02, OP_SLT = 8'h03, OP_SLTU = 8'h04;
    localparam logic [7:0] OP_AND = 8'h05, OP_OR = 8'h06, OP_XOR = 8'h07;
    localparam logic [7:0] OP_SLL = 8'h08, OP_SRL = 8'h09, OP_SRA = 8'h0A;
    localparam logic [7:0] OP_MUL = 8'h10, OP_MULH = 8'h11, OP_MULHSU = 8'h12, OP_MULHU = 8'h13;
    localparam logic [7:0] OP_DIV = 8'h14, OP_DIVU = 8'h15, OP_REM = 8'h16, OP_REMU = 8'h17;
    localparam int CW = $clog2(DIV_CYCLES + 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [7:0]        op_q, op_d;
    logic [XLEN:0]     op_a_q, op_a_d, op_b_q, op_b_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   quo_q, quo_d, rem_q, rem_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

    logic              is_mul, is_div, div_signed, stall;
    logic [XLEN-1:0]   alu_res, md_res, a_abs, b_abs;
    logic [XLEN-1:0]   quo_step, rem_step;
    logic [XLEN:0]     partial, trial;
    logic [2*XLEN-1:0] mul_a, mul_b;
    logic [4:0]        shamt;

    assign is_mul     = aluop_i inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    assign is_div     = aluop_i inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign div_signed = (aluop_i == OP_DIV) || (aluop_i == OP_REM);
    assign shamt      = reg2_i[4:0];
    assign a_abs      = (div_signed && reg1_i[XLEN-1]) ? -reg1_i : reg1_i;
    assign b_abs      = (div_signed && reg2_i[XLEN-1]) ? -reg2_i : reg2_i;

    always_comb begin
        // NOTE: default first so every path assigns alu_res; otherwise a latch is inferred.
        alu_res = '0;
        unique case (aluop_i)
            OP_ADD:  alu_res = reg1_i + reg2_i;
            OP_SUB:  alu_res = reg1_i - reg2_i;
            OP_SLT:  alu_res[0] = $signed(reg1_i) < $signed(reg2_i);
            OP_SLTU: alu_res[0] = reg1_i < reg2_i;
            OP_AND:  alu_res = reg1_i & reg2_i;
            OP_OR:   alu_res = reg1_i | reg2_i;
            OP_XOR:  alu_res = reg1_i ^ reg2_i;
            OP_SLL:  alu_res = reg1_i << shamt;
            OP_SRL:  alu_res = reg1_i >> shamt;
            OP_SRA:  alu_res = XLEN'($signed(reg1_i) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // Restoring divide step: quo_q shifts the dividend out as quotient bits shift in.
    always_comb begin
        partial = {rem_q, quo_q[XLEN-1]};
        trial   = partial - {1'b0, op_b_q[XLEN-1:0]};
        if (!trial[XLEN]) begin
            rem_step = trial[XLEN-1:0];
            quo_step = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_step = partial[XLEN-1:0];
            quo_step = {quo_q[XLEN-2:0], 1'b0};
        end
    end

    // Operands carry an explicit 33rd sign bit, so one signed product covers all three forms.
    assign mul_a = (2*XLEN)'($signed(op_a_q));
    assign mul_b = (2*XLEN)'($signed(op_b_q));

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        prod_d    = prod_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        stall     = 1'b0;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (is_mul) begin
                        op_d    = aluop_i;
                        op_a_d  = {(aluop_i != OP_MULHU) & reg1_i[XLEN-1], reg1_i};
                        op_b_d  = {(aluop_i == OP_MULH) & reg2_i[XLEN-1], reg2_i};
                        stall   = 1'b1;
                        state_d = S_MUL;
                    end else if (is_div) begin
                        op_d      = aluop_i;
                        stall     = 1'b1;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        if (reg2_i == '0) begin
                            quo_d   = '1;
                            rem_d   = reg1_i;
                            state_d = S_DONE;
                        end else if (div_signed && reg1_i == INT_MIN && reg2_i == '1) begin
                            quo_d   = INT_MIN;
                            rem_d   = '0;
                            state_d = S_DONE;
                        end else begin
                            quo_d     = a_abs;
                            rem_d     = '0;
                            op_b_d    = {1'b0, b_abs};
                            neg_quo_d = div_signed & (reg1_i[XLEN-1] ^ reg2_i[XLEN-1]);
                            neg_rem_d = div_signed & reg1_i[XLEN-1];
                            cnt_d     = CW'(DIV_CYCLES);
                            state_d   = S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    prod_d  = mul_a * mul_b;
                    stall   = 1'b1;
                    state_d = S_DONE;
                end
                S_DIV: begin
                    stall = 1'b1;
                    cnt_d = cnt_q - CW'(1);
                    quo_d = quo_step;
                    rem_d = rem_step;
                    if (cnt_q == CW'(1)) begin
                        quo_d   = neg_quo_q ? -quo_step : quo_step;
                        rem_d   = neg_rem_q ? -rem_step : rem_step;
                        state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            prod_q    <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of every other flop.
            state_q   <= state_d;
            op_q      <= op_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            prod_q    <= prod_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    always_comb begin
        md_res = '0;
        unique case (op_q)
            OP_MUL:                       md_res = prod_q[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: md_res = prod_q[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              md_res = quo_q;
            OP_REM, OP_REMU:              md_res = rem_q;
            default:                      md_res = '0;
        endcase
    end

    // Outputs are gated by rst directly so they clear asynchronously along with the state.
    always_comb begin
        wd_o       = '0;
        wreg_o     = 1'b0;
        wdata_o    = '0;
        stallreq_o = 1'b0;
        if (rst) begin
            wd_o       = wd_i;
            stallreq_o = stall;
            wreg_o     = wreg_i & ~stall;
            if (alusel_i != 3'd0)
                wdata_o = (state_q == S_DONE) ? md_res : alu_res;
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vector table, flush/reset sequences and
// randomized ops compared against a plain-arithmetic reference model.
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_i = 1'b0;
    logic [7:0]  aluop_i = '0;
    logic [2:0]  alusel_i = 3'd1;
    logic [31:0] reg1_i = '0, reg2_i = '0;
    logic [4:0]  wd_i = '0;
    logic        wreg_i = 1'b0;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;

    int tests = 0;
    int fails = 0;

    ex_muldiv dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          stalls;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result computed straight from the instruction definitions.
    function automatic logic [31:0] ref_model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int          sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (op)
            8'h01: return a + b;
            8'h02: return a - b;
            8'h03: return (sa < sb) ? 32'd1 : 32'd0;
            8'h04: return (a < b) ? 32'd1 : 32'd0;
            8'h05: return a & b;
            8'h06: return a | b;
            8'h07: return a ^ b;
            8'h08: return a << b[4:0];
            8'h09: return a >> b[4:0];
            8'h0A: return 32'(sa >>> b[4:0]);
            8'h10: begin p = 64'(longint'(sa) * longint'(sb)); return p[31:0]; end
            8'h11: begin p = 64'(longint'(sa) * longint'(sb)); return p[63:32]; end
            8'h12: begin p = 64'(longint'(sa) * longint'({32'd0, b})); return p[63:32]; end
            8'h13: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            8'h14: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            8'h15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            8'h16: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            8'h17: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_stalls(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op >= 8'h10 && op <= 8'h13) return 2;
        if (op >= 8'h14 && op <= 8'h17) begin
            if (b == 0) return 1;
            if ((op == 8'h14 || op == 8'h16) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
        return 0;
    endfunction

    // Drive one op (called just after a rising edge), count stall cycles, check the result cycle.
    task automatic do_test(input string name, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_stalls);
        int   stalls = 0;
        logic done = 1'b0;
        logic wreg_bad = 1'b0;
        logic [4:0] wd = 5'($urandom);
        aluop_i = op; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = 1'b1; alusel_i = 3'd1;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (stallreq_o) begin
                stalls++;
                if (wreg_o) wreg_bad = 1'b1;
                @(posedge clk);
                #1;
            end else begin
                done = 1'b1;
                check({name, "_result"}, wdata_o, exp);
                check({name, "_stalls"}, 32'(stalls), 32'(exp_stalls));
                check({name, "_wreg"}, {31'd0, wreg_o}, 32'd1);
                check({name, "_wd"}, {27'd0, wd_o}, {27'd0, wd});
                check({name, "_bubble"}, {31'd0, wreg_bad}, 32'd0);
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got stall after %0d cycles expected result", name, stalls);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];
    logic [7:0] rnd_ops[] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A,
                              8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};

    initial begin
        vecs = '{
            '{8'h01, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 0},
            '{8'h02, 32'h0,         32'h1,         32'hFFFF_FFFF, 0},
            '{8'h03, 32'h1,         32'hFFFF_FFFF, 32'h0,         0},
            '{8'h04, 32'h1,         32'hFFFF_FFFF, 32'h1,         0},
            '{8'h05, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0},
            '{8'h06, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0},
            '{8'h07, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0},
            '{8'h08, 32'h1,         32'h3F,        32'h8000_0000, 0},
            '{8'h09, 32'h8000_0000, 32'h21,        32'h4000_0000, 0},
            '{8'h0A, 32'h8000_0000, 32'h24,        32'hF800_0000, 0},
            '{8'h20, 32'h5,         32'h6,         32'h0,         0},
            '{8'h00, 32'h5,         32'h6,         32'h0,         0},
            '{8'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         2},
            '{8'h11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         2},
            '{8'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2},
            '{8'h12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2},
            '{8'h14, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 33},
            '{8'h16, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 33},
            '{8'h15, 32'd100,       32'h0,         32'hFFFF_FFFF, 1},
            '{8'h17, 32'd100,       32'h0,         32'd100,       1},
            '{8'h16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1},
            '{8'h14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
            '{8'h15, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF, 33},
            '{8'h14, 32'h7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33},
            '{8'h16, 32'h7,         32'hFFFF_FFFE, 32'h1,         33}
        };

        // Outputs held at zero under reset even with live inputs.
        aluop_i = 8'h01; reg1_i = 32'd1; reg2_i = 32'd2; wd_i = 5'd3; wreg_i = 1'b1;
        #3;
        check("reset_wdata", wdata_o, 32'd0);
        check("reset_wd", {27'd0, wd_o}, 32'd0);
        check("reset_wreg", {31'd0, wreg_o}, 32'd0);
        check("reset_stall", {31'd0, stallreq_o}, 32'd0);
        #4 rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i])
            do_test($sformatf("vec%0d_op%02h", i, vecs[i].op), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].exp, vecs[i].stalls);

        // alusel 0 zeroes the result while destination fields pass through.
        aluop_i = 8'h01; reg1_i = 32'd1; reg2_i = 32'd2; wd_i = 5'd9; wreg_i = 1'b1; alusel_i = 3'd0;
        @(negedge clk);
        check("nop_class_wdata", wdata_o, 32'd0);
        check("nop_class_wd", {27'd0, wd_o}, 32'd9);
        check("nop_class_wreg", {31'd0, wreg_o}, 32'd1);
        @(posedge clk);
        #1;
        alusel_i = 3'd1;

        // Flush on cycle 10 of a DIVU aborts it.
        aluop_i = 8'h15; reg1_i = 32'd1000; reg2_i = 32'd7;
        repeat (9) @(posedge clk);
        #1 flush_i = 1'b1;
        @(negedge clk);
        check("flush_stall", {31'd0, stallreq_o}, 32'd0);
        @(posedge clk);
        #1 flush_i = 1'b0; aluop_i = 8'h01; reg1_i = 32'd3; reg2_i = 32'd4;
        @(negedge clk);
        check("post_flush_idle", {31'd0, stallreq_o}, 32'd0);
        check("post_flush_add", wdata_o, 32'd7);
        @(posedge clk);
        #1;

        // Flush beats a start in the same cycle.
        aluop_i = 8'h14; reg1_i = 32'd100; reg2_i = 32'd3; flush_i = 1'b1;
        @(negedge clk);
        check("flush_start_stall", {31'd0, stallreq_o}, 32'd0);
        @(posedge clk);
        #1 flush_i = 1'b0; aluop_i = 8'h02; reg1_i = 32'd10; reg2_i = 32'd4;
        @(negedge clk);
        check("flush_start_idle", {31'd0, stallreq_o}, 32'd0);
        check("flush_start_sub", wdata_o, 32'd6);
        @(posedge clk);
        #1;
        do_test("after_flush_divu", 8'h15, 32'd1000, 32'd7, 32'd142, 33);

        // Reset dropped on cycle 5 of a divide clears outputs without a clock edge.
        aluop_i = 8'h15; reg1_i = 32'd1000; reg2_i = 32'd7; wd_i = 5'd12; wreg_i = 1'b1;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_wdata", wdata_o, 32'd0);
        check("midrst_wd", {27'd0, wd_o}, 32'd0);
        check("midrst_wreg", {31'd0, wreg_o}, 32'd0);
        check("midrst_stall", {31'd0, stallreq_o}, 32'd0);
        aluop_i = 8'h01; reg1_i = 32'h10; reg2_i = 32'h20;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_test("after_rst_add", 8'h01, 32'h10, 32'h20, 32'h30, 0);

        // Randomized ops, biased toward the divide corner operands.
        for (int n = 0; n < 250; n++) begin
            logic [7:0]  op;
            logic [31:0] a, b;
            op = rnd_ops[$urandom_range(0, rnd_ops.size() - 1)];
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'h8000_0000;
                default: ;
            endcase
            do_test($sformatf("rnd%0d_op%02h", n, op), op, a, b, ref_model(op, a, b), ref_stalls(op, a, b));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
